ex_muldiv: RTL and testbench

Iterative multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register. It consumes the forwarded rs/rt operands and instruction word that ID/EX presents to EX. It executes MULT/MULTU/DIV/DIVU over multiple cycles into private HI/LO registers and serves MFHI/MFLO/MTHI/MTLO. While an operation is in flight it raises a stall request to the stall controller, which freezes PC, IF/ID and ID/EX and bubbles EX/MEM.

---
 rtl/ex_muldiv_if.sv | 20 ++
 rtl/ex_muldiv.sv | 85 ++++++++
 tb/tb_ex_muldiv.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/ex_muldiv_if.sv
// ex_muldiv_if: EX-stage operand/instruction inputs and mul/div results for ex_muldiv
interface ex_muldiv_if;
  logic [31:0] ex_ins;
  logic [31:0] ex_reg1;
  logic [31:0] ex_reg2;
  logic        md_flush;
  logic        md_busy;
  logic        md_is_mf;
  logic [31:0] md_mf_result;
  logic [31:0] md_hi;
  logic [31:0] md_lo;
  modport master (
    output ex_ins, ex_reg1, ex_reg2, md_flush,
    input  md_busy, md_is_mf, md_mf_result, md_hi, md_lo
  );
  modport slave (
    input  ex_ins, ex_reg1, ex_reg2, md_flush,
    output md_busy, md_is_mf, md_mf_result, md_hi, md_lo
  );
endinterface

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative MULT/MULTU/DIV/DIVU unit with private HI/LO and MFHI/MFLO/MTHI/MTLO access
module ex_muldiv (
  input logic       sys_clk,
  input logic       rst_n,
  ex_muldiv_if.slave md
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t      state, state_nx;
  logic [4:0]  cnt;
  logic [31:0] hi, lo, acc, sh, dvs, a_mag, b_mag, diff;
  logic [32:0] mul_add, t;
  logic [63:0] prod, prod_s;
  logic        r_type, is_md, is_dv, sgn, a_neg, b_neg, start, mt_hi, mt_lo, ge;
  logic        is_div, neg_q, neg_r, dz;
  assign r_type = md.ex_ins[31:26] == 6'd0;
  assign is_dv  = r_type && md.ex_ins[5:1] == 5'b01101;
  assign is_md  = is_dv || (r_type && md.ex_ins[5:1] == 5'b01100);
  assign sgn    = !md.ex_ins[0];
  assign a_neg  = sgn && md.ex_reg1[31];
  assign b_neg  = sgn && md.ex_reg2[31];
  assign a_mag  = a_neg ? -md.ex_reg1 : md.ex_reg1;
  assign b_mag  = b_neg ? -md.ex_reg2 : md.ex_reg2;
  assign start  = state == IDLE && is_md && !md.md_flush;
  assign mt_hi  = state == IDLE && !md.md_flush && r_type && md.ex_ins[5:0] == 6'h11;
  assign mt_lo  = state == IDLE && !md.md_flush && r_type && md.ex_ins[5:0] == 6'h13;
  // acc:sh is the shifting product for multiply and remainder:quotient for divide
  assign t       = {acc, sh[31]};
  assign ge      = t >= {1'b0, dvs};
  assign diff    = t[31:0] - dvs;
  assign mul_add = sh[0] ? {1'b0, acc} + {1'b0, dvs} : {1'b0, acc};
  assign prod    = {acc, sh};
  assign prod_s  = neg_q ? -prod : prod;
  assign md.md_is_mf     = r_type && (md.ex_ins[5:0] == 6'h10 || md.ex_ins[5:0] == 6'h12);
  assign md.md_mf_result = !r_type ? '0 : md.ex_ins[5:0] == 6'h10 ? hi : md.ex_ins[5:0] == 6'h12 ? lo : '0;
  assign md.md_hi = hi;
  assign md.md_lo = lo;
  // Next state and stall request; flush aborts and drops the stall in the same cycle
  always_comb begin
    state_nx = md.md_flush ? IDLE :
               state == IDLE ? (is_md ? BUSY : IDLE) :
               state == BUSY ? (cnt == 5'd0 ? DONE : BUSY) : IDLE;
    md.md_busy = !md.md_flush && ((state == IDLE && is_md) || state == BUSY);
  end
  // State register
  always_ff @(posedge sys_clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // Operand capture on start, then one radix-2 shift-add or restoring-subtract step per BUSY cycle
  always_ff @(posedge sys_clk or negedge rst_n)
    if (!rst_n) begin
      cnt    <= '0;
      acc    <= '0;
      sh     <= '0;
      dvs    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
    end else if (start) begin
      cnt    <= 5'd31;
      acc    <= '0;
      sh     <= a_mag;
      dvs    <= b_mag;
      is_div <= is_dv;
      neg_q  <= a_neg ^ b_neg;
      neg_r  <= a_neg;
      dz     <= md.ex_reg2 == 32'd0;
    end else if (state == BUSY) begin
      cnt <= cnt - 5'd1;
      acc <= is_div ? (ge ? diff : t[31:0]) : mul_add[32:1];
      sh  <= is_div ? {sh[30:0], ge} : {mul_add[0], sh[31:1]};
    end
  // HI/LO: sign-corrected result in DONE, MTHI/MTLO in IDLE, nothing while flushing
  always_ff @(posedge sys_clk or negedge rst_n)
    if (!rst_n) begin
      hi <= '0;
      lo <= '0;
    end else if (state == DONE && !md.md_flush) begin
      hi <= is_div ? (neg_r ? -acc : acc) : prod_s[63:32];
      lo <= is_div ? (dz ? '1 : neg_q ? -sh : sh) : prod_s[31:0];
    end else begin
      if (mt_hi) hi <= md.ex_reg1;
      if (mt_lo) lo <= md.ex_reg1;
    end
endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: randomized bench for ex_muldiv against a cycle-level arithmetic reference model
module tb_ex_muldiv;
  localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A, F_DIVU = 6'h1B;
  localparam logic [5:0] F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO = 6'h12, F_MTLO = 6'h13;
  logic sys_clk, rst_n, chk_en;
  int   tests, fails, busy_cnt;
  ex_muldiv_if bus();
  ex_muldiv dut (.sys_clk(sys_clk), .rst_n(rst_n), .md(bus));
  // reference model state: architectural HI/LO, cycles left of the op in EX, pending result
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  int          m_rem;
  logic        exp_busy, exp_mf;
  logic [31:0] exp_res;
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int op_of(input logic [31:0] i);
    if (i[31:26] != 6'd0) return -1;
    case (i[5:0])
      F_MULT: return 0;
      F_MULTU: return 1;
      F_DIV: return 2;
      F_DIVU: return 3;
      F_MFHI: return 4;
      F_MTHI: return 5;
      F_MFLO: return 6;
      F_MTLO: return 7;
      default: return -1;
    endcase
  endfunction
  function automatic logic [63:0] md_ref(input int op, input logic [31:0] a, input logic [31:0] b);
    int q, r;
    case (op)
      0: return 64'(longint'($signed(a)) * longint'($signed(b)));
      1: return {32'd0, a} * {32'd0, b};
      2: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {r, q};
      end
      default: return b == 32'd0 ? {a, 32'hFFFFFFFF} : {a % b, a / b};
    endcase
  endfunction
  function automatic logic [31:0] r_ins(input logic [5:0] fn);
    return {6'd0, 20'($urandom), fn};
  endfunction
  // single compare process: every checked cycle, DUT outputs against the model
  always @(negedge sys_clk)
    if (chk_en) begin
      busy_cnt += int'(bus.md_busy);
      chk("md_busy", 32'(bus.md_busy), 32'(exp_busy));
      chk("md_is_mf", 32'(bus.md_is_mf), 32'(exp_mf));
      chk("md_mf_result", bus.md_mf_result, exp_res);
      chk("md_hi", bus.md_hi, m_hi);
      chk("md_lo", bus.md_lo, m_lo);
    end
  // one EX cycle: drive inputs, form expectations, cross the edge, advance the model
  task automatic cyc(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b, input logic fl);
    int op;
    op = op_of(i);
    bus.ex_ins = i;
    bus.ex_reg1 = a;
    bus.ex_reg2 = b;
    bus.md_flush = fl;
    exp_busy = !fl && (m_rem == 0 ? (op >= 0 && op <= 3) : m_rem > 1);
    exp_mf = op == 4 || op == 6;
    exp_res = op == 4 ? m_hi : op == 6 ? m_lo : 32'd0;
    chk_en = 1'b1;
    @(posedge sys_clk);
    #1;
    if (!rst_n) return;
    if (fl) m_rem = 0;
    else if (m_rem == 0) begin
      if (op >= 0 && op <= 3) begin
        {p_hi, p_lo} = md_ref(op, a, b);
        m_rem = 33;
      end else if (op == 5) m_hi = a;
      else if (op == 7) m_lo = a;
    end else if (m_rem == 1) begin
      m_hi = p_hi;
      m_lo = p_lo;
      m_rem = 0;
    end else m_rem--;
  endtask
  // hold an instruction in EX until the stall releases it, optionally flushing at cycle flush_at
  task automatic issue(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b,
                       input int flush_at, output int n);
    n = 0;
    busy_cnt = 0;
    do begin
      cyc(i, a, b, n == flush_at);
      n++;
    end while (exp_busy && n < 100);
  endtask
  task automatic mf_lit(input logic [5:0] fn, input logic [31:0] exp, input string name);
    logic [31:0] i;
    int n;
    i = r_ins(fn);
    bus.ex_ins = i;
    #1;
    chk({name, "_is_mf"}, 32'(bus.md_is_mf), 32'd1);
    chk({name, "_res"}, bus.md_mf_result, exp);
    issue(i, 32'd0, 32'd0, -1, n);
  endtask
  task automatic op_lit(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input string name);
    int n;
    issue(r_ins(fn), a, b, -1, n);
    cyc(32'd0, 32'd0, 32'd0, 1'b0);
    chk({name, "_occupancy"}, 32'(n), 32'd34);
    chk({name, "_busy_cycles"}, 32'(busy_cnt), 32'd33);
    chk({name, "_hi"}, bus.md_hi, ehi);
    chk({name, "_lo"}, bus.md_lo, elo);
    chk({name, "_model_hi"}, m_hi, ehi);
    chk({name, "_model_lo"}, m_lo, elo);
  endtask
  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom_range(0, 20));
      4: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction
  initial begin
    int n, sel, fa;
    logic [31:0] i;
    tests = 0;
    fails = 0;
    busy_cnt = 0;
    chk_en = 1'b0;
    m_hi = '0;
    m_lo = '0;
    p_hi = '0;
    p_lo = '0;
    m_rem = 0;
    rst_n = 1'b0;
    bus.ex_ins = '0;
    bus.ex_reg1 = '0;
    bus.ex_reg2 = '0;
    bus.md_flush = 1'b0;
    @(posedge sys_clk);
    #1;
    chk("reset_hi", bus.md_hi, 32'd0);
    chk("reset_lo", bus.md_lo, 32'd0);
    chk("reset_busy", 32'(bus.md_busy), 32'd0);
    rst_n = 1'b1;
    op_lit(F_MULT, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE, "mult");
    op_lit(F_MULTU, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, "multu");
    op_lit(F_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg");
    op_lit(F_DIV, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, "div_ovf");
    op_lit(F_DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFFFFFF, "divu_zero");
    issue(r_ins(F_MTHI), 32'h12345678, 32'd0, -1, n);
    mf_lit(F_MFHI, 32'h12345678, "mthi_mfhi");
    issue(r_ins(F_MTLO), 32'h9ABCDEF0, 32'd0, -1, n);
    mf_lit(F_MFLO, 32'h9ABCDEF0, "mtlo_mflo");
    // reset in cycle 10 of a MULT, with ex_ins dropped to a bubble alongside it
    i = r_ins(F_MULT);
    for (int k = 0; k < 10; k++) cyc(i, 32'd3, 32'd5, 1'b0);
    rst_n = 1'b0;
    m_hi = '0;
    m_lo = '0;
    m_rem = 0;
    cyc(32'd0, 32'd0, 32'd0, 1'b0);
    chk("midop_reset_busy", 32'(bus.md_busy), 32'd0);
    chk("midop_reset_hi", bus.md_hi, 32'd0);
    chk("midop_reset_lo", bus.md_lo, 32'd0);
    rst_n = 1'b1;
    // flush in cycle 10 of a MULT leaves HI/LO as they were
    issue(r_ins(F_MTHI), 32'hA5A5A5A5, 32'd0, -1, n);
    issue(r_ins(F_MTLO), 32'h5A5A5A5A, 32'd0, -1, n);
    issue(r_ins(F_MULT), 32'd1000, 32'd1000, 10, n);
    chk("flush_occupancy", 32'(n), 32'd11);
    cyc(32'd0, 32'd0, 32'd0, 1'b0);
    chk("flush_hi", bus.md_hi, 32'hA5A5A5A5);
    chk("flush_lo", bus.md_lo, 32'h5A5A5A5A);
    chk("flush_idle_busy", 32'(bus.md_busy), 32'd0);
    // random instruction stream, back-to-back, with occasional flushes
    for (int k = 0; k < 80; k++) begin
      sel = $urandom_range(0, 11);
      case (sel)
        0, 1, 2, 3: i = r_ins(F_MULT + 6'(sel));
        4: i = r_ins(F_MFHI);
        5: i = r_ins(F_MTHI);
        6: i = r_ins(F_MFLO);
        7: i = r_ins(F_MTLO);
        8: i = 32'd0;
        9: i = {6'($urandom_range(1, 63)), 20'($urandom), F_DIV};
        10: i = r_ins(6'h20);
        default: i = r_ins(6'($urandom_range(F_MULT, F_DIVU)));
      endcase
      fa = $urandom_range(0, 5) == 0 ? $urandom_range(0, 35) : -1;
      issue(i, rnd32(), rnd32(), fa, n);
    end
    cyc(32'd0, 32'd0, 32'd0, 1'b0);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
